// File: rtl/shared_mul_pkg.sv
// shared_mul_pkg: default parameters and the granted-operation record for shared_mul_arbiter
package shared_mul_pkg;
  localparam int mul_n_def = 8;
  localparam int mul_n_req_def = 4;
  localparam int mul_stages_def = 2;
  localparam int mul_max_n = 32;
  localparam int mul_max_id_w = 8;
  typedef struct packed {
    logic [mul_max_n-1:0] a;
    logic [mul_max_n-1:0] b;
    logic signed_mul;
    logic [mul_max_id_w-1:0] id;
    logic vld;
  } mul_op_t;
endpackage

// File: rtl/shared_mul_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant scanning upward from ptr, ptr moves past each winner
module rr_arbiter import shared_mul_pkg::*; #(
  parameter int n_req = mul_n_req_def
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [n_req-1:0] req,
  input  logic             advance,
  output logic [n_req-1:0] grant
);
  localparam int id_w = $clog2(n_req);
  logic [id_w-1:0] ptr, idx, j;
  always_comb begin
    grant = '0;
    idx = '0;
    j = '0;
    for (int k = n_req - 1; k >= 0; k--) begin
      j = id_w'((int'(ptr) + k) % n_req);
      if (req[j]) begin
        grant = '0;
        grant[j] = rst_n;
        idx = j;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) ptr <= '0;
    else if (advance) ptr <= id_w'((int'(idx) + 1) % n_req);
  end
endmodule

// File: rtl/shared_mul_arbiter.sv
// shared_mul_arbiter: one pipelined multiplier shared round-robin; SHARED_MUL_RSP_REG_EN adds an output register
module shared_mul_arbiter import shared_mul_pkg::*; #(
  parameter int n = mul_n_def,
  parameter int n_req = mul_n_req_def,
  parameter int mul_stages = mul_stages_def,
  parameter int id_w = $clog2(n_req)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [n_req-1:0]   req_vld,
  output logic [n_req-1:0]   req_rdy,
  input  logic [n_req*n-1:0] req_a,
  input  logic [n_req*n-1:0] req_b,
  input  logic [n_req-1:0]   req_signed,
  output logic               rsp_vld,
  output logic [id_w-1:0]    rsp_id,
  output logic [2*n-1:0]     rsp_res,
  output logic               busy
);
  localparam logic [2*mul_max_n-1:0] hi = {2*mul_max_n{1'b1}} << n;
  mul_op_t sel;
  logic [2*mul_max_n-1:0] a_x, b_x;
  logic [mul_stages-1:0] vld_q;
  logic [mul_stages-1:0][id_w-1:0] id_q;
  logic [mul_stages-1:0][2*n-1:0] res_q;
  rr_arbiter #(.n_req(n_req)) u_arb (
    .clk(clk), .rst_n(rst_n), .req(req_vld), .advance(|req_rdy), .grant(req_rdy)
  );
  always_comb begin
    sel = '0;
    for (int i = 0; i < n_req; i++)
      if (req_rdy[i])
        sel = '{a: mul_max_n'(req_a[i*n +: n]), b: mul_max_n'(req_b[i*n +: n]),
                signed_mul: req_signed[i], id: mul_max_id_w'(i), vld: 1'b1};
  end
  // idle cycles leave sel all-zero, so the product and tag stages carry zeros alongside vld=0
  assign a_x = {{mul_max_n{1'b0}}, sel.a} | ((sel.signed_mul && sel.a[n-1]) ? hi : '0);
  assign b_x = {{mul_max_n{1'b0}}, sel.b} | ((sel.signed_mul && sel.b[n-1]) ? hi : '0);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      id_q <= '0;
      res_q <= '0;
    end else begin
      vld_q[0] <= sel.vld;
      id_q[0] <= id_w'(sel.id);
      res_q[0] <= (2*n)'(a_x * b_x);
      for (int s = 1; s < mul_stages; s++) begin
        vld_q[s] <= vld_q[s-1];
        id_q[s] <= id_q[s-1];
        res_q[s] <= res_q[s-1];
      end
    end
  end
`ifdef SHARED_MUL_RSP_REG_EN
  logic o_vld;
  logic [id_w-1:0] o_id;
  logic [2*n-1:0] o_res;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_vld <= 1'b0;
      o_id <= '0;
      o_res <= '0;
    end else begin
      o_vld <= vld_q[mul_stages-1];
      o_id <= id_q[mul_stages-1];
      o_res <= res_q[mul_stages-1];
    end
  end
  assign rsp_vld = o_vld;
  assign rsp_id = o_id;
  assign rsp_res = o_res;
  assign busy = |vld_q | o_vld;
`else
  assign rsp_vld = vld_q[mul_stages-1];
  assign rsp_id = id_q[mul_stages-1];
  assign rsp_res = res_q[mul_stages-1];
  assign busy = |vld_q;
`endif
endmodule

// File: tb/tb_shared_mul_arbiter.sv
// tb_shared_mul_arbiter: directed checks of arbitration order, products, latency and reset flush
module tb_shared_mul_arbiter;
`ifdef SHARED_MUL_RSP_REG_EN
  localparam int lat = 3;
`else
  localparam int lat = 2;
`endif
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] req_vld, req_rdy, req_signed;
  logic [31:0] req_a, req_b;
  logic rsp_vld, busy;
  logic [1:0] rsp_id;
  logic [15:0] rsp_res;
  int total = 0;
  int bad = 0;

  shared_mul_arbiter #(.n(8), .n_req(4), .mul_stages(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_rdy(req_rdy),
    .req_a(req_a), .req_b(req_b), .req_signed(req_signed),
    .rsp_vld(rsp_vld), .rsp_id(rsp_id), .rsp_res(rsp_res), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic nxt;
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic single_op(input int idx, input logic [7:0] a, input logic [7:0] b,
                           input logic s, input logic [15:0] exp);
    req_a = '0;
    req_b = '0;
    req_signed = '0;
    req_vld = '0;
    req_a[idx*8 +: 8] = a;
    req_b[idx*8 +: 8] = b;
    req_signed[idx] = s;
    req_vld[idx] = 1'b1;
    #1;
    check("op_rdy", req_rdy, 32'(1 << idx));
    nxt();
    req_vld = '0;
    check("op_busy", busy, 1);
    for (int k = 1; k < lat; k++) begin
      check("op_early_vld", rsp_vld, 0);
      nxt();
    end
    check("op_vld", rsp_vld, 1);
    check("op_id", rsp_id, idx);
    check("op_res", rsp_res, exp);
    nxt();
    check("op_vld_pulse", rsp_vld, 0);
    check("op_id_zero", rsp_id, 0);
    check("op_res_zero", rsp_res, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    req_vld = '0;
    req_signed = '0;
    req_a = {8'd4, 8'd3, 8'd2, 8'd1};
    req_b = {8'd5, 8'd4, 8'd3, 8'd2};
    repeat (2) @(negedge clk);
    req_vld = 4'hF;
    #1;
    check("rst_rdy", req_rdy, 0);
    check("rst_vld", rsp_vld, 0);
    check("rst_id", rsp_id, 0);
    check("rst_res", rsp_res, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    #1;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) nxt();
      check("rr_rdy", req_rdy, 32'(1 << (c % 4)));
      if (c >= lat) begin
        check("rr_vld", rsp_vld, 1);
        check("rr_id", rsp_id, c - lat);
        check("rr_res", rsp_res, (c - lat + 1) * (c - lat + 2));
      end else check("rr_idle", rsp_vld, 0);
    end
    nxt();
    req_vld = '0;
    repeat (lat + 1) nxt();
    check("drain_busy", busy, 0);
    check("drain_vld", rsp_vld, 0);
    req_vld = 4'b1010;
    #1;
    check("fair_rdy0", req_rdy, 4'b1000);
    nxt();
    check("fair_rdy1", req_rdy, 4'b0010);
    nxt();
    check("fair_rdy2", req_rdy, 4'b1000);
    req_vld = '0;
    repeat (lat + 1) nxt();
    check("fair_busy", busy, 0);
    single_op(2, 8'hFF, 8'hFF, 1'b0, 16'hFE01);
    single_op(0, 8'hFF, 8'h03, 1'b1, 16'hFFFD);
    single_op(0, 8'hFF, 8'h03, 1'b0, 16'h02FD);
    single_op(3, 8'h80, 8'h7F, 1'b1, 16'hC080);
    req_vld = 4'b0110;
    #1;
    check("flush_rdy", req_rdy, 4'b0010);
    nxt();
    rst_n = 1'b0;
    #1;
    check("flush_rdy_in_rst", req_rdy, 0);
    nxt();
    rst_n = 1'b1;
    #1;
    check("flush_vld", rsp_vld, 0);
    check("flush_busy", busy, 0);
    check("flush_ptr", req_rdy, 4'b0010);
    req_vld = '0;
    for (int k = 0; k <= lat; k++) begin
      nxt();
      check("flush_no_rsp", rsp_vld, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
